sar_adc_ctrl: RTL and testbench

- Digital successor-approximation controller that consumes the buffered bandgap reference.
- Drives the binary-weighted capacitive DAC code and the sample/hold switch.
- Reads a comparator that compares the held input against the DAC output scaled from the buffered bandgap reference.
- Sits directly downstream of the reference/buffer stage and turns an analog pin voltage into a WIDTH-bit code on the digital pins.

---
 rtl/sar_adc_ctrl.sv | 138 +++++++++++++
 tb/tb_sar_adc_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: sample/hold, binary-search DAC trials, result capture.
// Optional macro CMP_SYNC_EN adds a 2-flop comparator synchronizer and a wider trial window.
module sar_adc_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SAMPLE_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_in,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovr
);

`ifdef CMP_SYNC_EN
    // Two extra cycles per trial let the synchronized comparator catch up with the new code.
    localparam int unsigned WIN = SETTLE_CYCLES + 3;

    logic [1:0] cmp_sync;
    logic       cmp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cmp_sync <= '0;
        else     cmp_sync <= {cmp_sync[0], cmp_in};
    end
    assign cmp = cmp_sync[1];
`else
    localparam int unsigned WIN = SETTLE_CYCLES + 1;

    logic cmp;
    assign cmp = cmp_in;
`endif

    localparam int unsigned SCW = $clog2(SAMPLE_CYCLES + 1);
    localparam int unsigned TCW = $clog2(WIN + 1);
    localparam int unsigned IW  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_TRIAL, S_DONE} state_t;

    state_t           state;
    logic [SCW-1:0]   scnt;
    logic [TCW-1:0]   tcnt;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] w_upd;
    logic [WIDTH-1:0] next_bit;

    // Working value after this trial's decision, and the next lower trial bit.
    always_comb begin
        w_upd    = cmp ? (w | (WIDTH'(1) << idx)) : w;
        next_bit = WIDTH'(1) << (idx - 1'b1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            scnt     <= '0;
            tcnt     <= '0;
            idx      <= '0;
            w        <= '0;
            sample   <= 1'b0;
            dac_code <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            ovr      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_SAMPLE;
                        scnt     <= SCW'(SAMPLE_CYCLES - 1);
                        sample   <= 1'b1;
                        busy     <= 1'b1;
                        dac_code <= '0;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        sample   <= 1'b0;
                        busy     <= 1'b0;
                        dac_code <= '0;
                    end else if (scnt == '0) begin
                        state    <= S_TRIAL;
                        sample   <= 1'b0;
                        idx      <= IW'(WIDTH - 1);
                        w        <= '0;
                        tcnt     <= TCW'(WIN - 1);
                        dac_code <= MSB;
                    end else begin
                        scnt <= scnt - 1'b1;
                    end
                end
                S_TRIAL: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        dac_code <= '0;
                    end else if (tcnt != '0) begin
                        tcnt <= tcnt - 1'b1;
                    end else begin
                        // Decision edge: keep or drop the trial bit.
                        w <= w_upd;
                        if (idx == '0) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            result   <= w_upd;
                            ovr      <= &w_upd;
                            dac_code <= w_upd;
                        end else begin
                            idx      <= idx - 1'b1;
                            tcnt     <= TCW'(WIN - 1);
                            dac_code <= w_upd | next_bit;
                        end
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    dac_code <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl: comparator model drives cmp_in, monitor checks each done.
module tb_sar_adc_ctrl;
    localparam int W   = 8;
    localparam int S   = 4;
    localparam int ST  = 1;
`ifdef CMP_SYNC_EN
    localparam int WIN = ST + 3;
`else
    localparam int WIN = ST + 1;
`endif
    localparam int LAT = 1 + S + W * WIN;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic         cmp_in;
    logic         sample;
    logic [W-1:0] dac_code;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         ovr;

    int           mode;   // 0: cmp tied 0, 1: cmp tied 1, 2: ideal comparator against vin
    logic [W-1:0] vin;

    typedef struct {
        int           cyc;
        logic [W-1:0] res;
        logic         ovr;
    } exp_t;

    exp_t sb[$];
    int   ncyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(ST)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .cmp_in   (cmp_in),
        .sample   (sample),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovr      (ovr)
    );

    always #5 clk = ~clk;

    assign cmp_in = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : (vin >= dac_code);

    // Successive approximation of an ideal comparator converges on the input code itself.
    function automatic logic [W-1:0] model(input int m, input logic [W-1:0] v);
        if (m == 0)      return '0;
        else if (m == 1) return '1;
        else             return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, ncyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input int cyc, input logic [W-1:0] r);
        exp_t e;
        e.cyc = cyc;
        e.res = r;
        e.ovr = &r;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        ncyc = ncyc + 1;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", ncyc);
            end else begin
                e = sb.pop_front();
                check("done_cycle", ncyc, e.cyc);
                check("result", 32'(result), 32'(e.res));
                check("ovr", 32'(ovr), 32'(e.ovr));
            end
        end
    end

    task automatic run_conv(input int m, input logic [W-1:0] v, input bit repulse, input bit with_abort);
        int t0;
        logic [W-1:0] r;
        mode  = m;
        vin   = v;
        r     = model(m, v);
        start = 1'b1;
        abort = with_abort;
        t0    = ncyc;
        push_exp(t0 + LAT, r);
        for (int n = 1; n <= LAT + 1; n++) begin
            tick();
            start = repulse && (n == 5 || n == 15);
            abort = with_abort && (n == LAT);
            check("sample", 32'(sample), 32'(n <= S));
            check("busy", 32'(busy), 32'(n <= LAT));
            if (n <= S)       check("dac_in_sample", 32'(dac_code), 32'(0));
            if (n == LAT)     check("dac_final", 32'(dac_code), 32'(r));
            if (n == LAT + 1) check("dac_idle", 32'(dac_code), 32'(0));
        end
        abort = 1'b0;
        check("sb_drained", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 2;
        vin   = '0;
        tick();
        tick();
        check("rst_sample", 32'(sample), 32'(0));
        check("rst_dac", 32'(dac_code), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_result", 32'(result), 32'(0));
        check("rst_ovr", 32'(ovr), 32'(0));
        rst = 1'b0;
        tick();

        run_conv(2, 8'hA5, 1'b0, 1'b0);
        run_conv(0, 8'h00, 1'b0, 1'b0);
        run_conv(1, 8'h00, 1'b0, 1'b0);
        run_conv(2, 8'h3C, 1'b0, 1'b0);
        run_conv(2, 8'hA5, 1'b1, 1'b0);
        run_conv(2, 8'h81, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++)
            run_conv(2, W'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), 1'b0);

        // Abort mid-trial: no done, result retained.
        run_conv(2, 8'h5A, 1'b0, 1'b0);
        vin   = 8'h13;
        start = 1'b1;
        t0    = ncyc;
        for (int n = 1; n <= 10; n++) begin
            tick();
            start = 1'b0;
            abort = (n == 10);
        end
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_sample", 32'(sample), 32'(0));
        check("abort_dac", 32'(dac_code), 32'(0));
        check("abort_cycle", 32'(ncyc - t0), 32'(11));
        for (int n = 0; n < LAT + 4; n++) tick();
        check("abort_result", 32'(result), 32'(8'h5A));
        check("abort_ovr", 32'(ovr), 32'(0));

        // start held high: one conversion every LAT+1 cycles.
        mode  = 2;
        vin   = 8'h77;
        start = 1'b1;
        t0    = ncyc;
        for (int k = 0; k < 3; k++) push_exp(t0 + LAT + k * (LAT + 1), 8'h77);
        for (int n = 1; n <= 3 * (LAT + 1); n++) begin
            tick();
            if (n == 2 * (LAT + 1) + 2) start = 1'b0;
        end
        check("held_drained", 32'(sb.size()), 32'(0));
        check("held_idle", 32'(busy), 32'(0));

        // Asynchronous reset mid-trial.
        vin   = 8'hC3;
        start = 1'b1;
        t0    = ncyc;
        push_exp(t0 + LAT, 8'hC3);
        for (int n = 1; n <= 10; n++) begin
            tick();
            start = 1'b0;
        end
        check("pre_rst_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        sb.delete();
        #1;
        check("arst_sample", 32'(sample), 32'(0));
        check("arst_dac", 32'(dac_code), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_done", 32'(done), 32'(0));
        check("arst_result", 32'(result), 32'(0));
        check("arst_ovr", 32'(ovr), 32'(0));
        tick();
        rst = 1'b0;
        tick();
        run_conv(2, 8'hC3, 1'b0, 1'b0);
        run_conv(1, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
